// File: rtl/systolic_array_feeder_pkg.sv
// Shared types and helpers for the systolic array feeder: sequencer states,
// drain length and lane-slice arithmetic.
package systolic_array_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } feeder_state_e;

  localparam int DEFAULT_N    = 4;
  localparam int DRAIN_CYCLES = 2 * DEFAULT_N - 2;

  // Cycles needed for the last vector to leave the far corner of an n x n grid.
  function automatic int drain_cycles(input int n);
    return (n > 1) ? (2 * n - 2) : 0;
  endfunction

  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/systolic_array_feeder_skew_delay_line.sv
// Enable-gated shift register used to skew one array row by DEPTH steps.
module skew_delay_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] stage_q [DEPTH];
  logic [DATA_WIDTH-1:0] stage_d [DEPTH];

  // Next-stage values: shift on enable, otherwise hold so the array freezes.
  always_comb begin
    stage_d = stage_q;
    if (en) begin
      stage_d[0] = din;
      for (int d = 1; d < DEPTH; d++) begin
        stage_d[d] = stage_q[d-1];
      end
    end else begin
      stage_d = stage_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) begin
        stage_q[d] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_array_feeder.sv
// Sequencer for a weight-stationary N x N PE grid: loads weight rows, then
// streams skewed activation vectors and drains the grid before signalling done.
module systolic_array_feeder
  import systolic_array_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    reuse_weights,
  input  logic [CNT_W-1:0]        num_vectors,
  output logic                    busy,
  output logic                    done,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [N*DATA_WIDTH-1:0] w_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [N*DATA_WIDTH-1:0] a_data,
  output logic [N-1:0]            pe_load_weight,
  output logic [N*DATA_WIDTH-1:0] pe_weight,
  output logic                    pe_valid,
  output logic [N*DATA_WIDTH-1:0] pe_input
);

  localparam int BW        = N * DATA_WIDTH;
  localparam int ROW_W     = (N > 1) ? $clog2(N) : 1;
  localparam int DRAIN_CYC = drain_cycles(N);
  localparam int DRN_W     = $clog2(2 * N + 1);

  feeder_state_e    state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [DRN_W-1:0] drn_q, drn_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pe_valid_q, pe_valid_d;
  logic [N-1:0]     pe_load_weight_q, pe_load_weight_d;
  logic [BW-1:0]    pe_weight_q, pe_weight_d;

  logic             w_fire_s;
  logic             a_fire_s;
  logic             step_s;
  logic [BW-1:0]    row_din_s;

  assign w_ready  = (state_q == LOAD_W);
  assign a_ready  = (state_q == STREAM);
  assign w_fire_s = w_valid & w_ready;
  assign a_fire_s = a_valid & a_ready;
  // One array step per accepted vector, plus every drain cycle (zeros flushed in).
  assign step_s   = a_fire_s | (state_q == DRAIN);
  assign row_din_s = (state_q == STREAM) ? a_data : {BW{1'b0}};

  // Next-state, counter and output decode.
  always_comb begin
    state_d          = state_q;
    row_d            = row_q;
    vec_d            = vec_q;
    k_d              = k_q;
    drn_d            = drn_q;
    done_d           = 1'b0;
    pe_load_weight_d = {N{1'b0}};
    pe_weight_d      = pe_weight_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d   = num_vectors;
          vec_d = {CNT_W{1'b0}};
          drn_d = {DRN_W{1'b0}};
          row_d = {ROW_W{1'b0}};
          if (!reuse_weights) begin
            state_d = LOAD_W;
          end else if (num_vectors != {CNT_W{1'b0}}) begin
            state_d = STREAM;
          end else begin
            state_d = FINISH;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_W: begin
        if (w_fire_s) begin
          pe_load_weight_d[row_q] = 1'b1;
          pe_weight_d             = w_data;
          if (row_q == ROW_W'(N - 1)) begin
            row_d   = {ROW_W{1'b0}};
            state_d = (k_q != {CNT_W{1'b0}}) ? STREAM : FINISH;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end else begin
          pe_load_weight_d = {N{1'b0}};
        end
      end
      STREAM: begin
        if (a_fire_s) begin
          vec_d = vec_q + CNT_W'(1);
          if (vec_q == k_q - CNT_W'(1)) begin
            drn_d   = {DRN_W{1'b0}};
            state_d = (DRAIN_CYC == 0) ? FINISH : DRAIN;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = STREAM;
        end
      end
      DRAIN: begin
        if (drn_q == DRN_W'(DRAIN_CYC - 1)) begin
          state_d = FINISH;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d     = (state_d != IDLE);
    pe_valid_d = step_s;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      row_q            <= {ROW_W{1'b0}};
      vec_q            <= {CNT_W{1'b0}};
      k_q              <= {CNT_W{1'b0}};
      drn_q            <= {DRN_W{1'b0}};
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      pe_valid_q       <= 1'b0;
      pe_load_weight_q <= {N{1'b0}};
      pe_weight_q      <= {BW{1'b0}};
    end else begin
      state_q          <= state_d;
      row_q            <= row_d;
      vec_q            <= vec_d;
      k_q              <= k_d;
      drn_q            <= drn_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
      pe_valid_q       <= pe_valid_d;
      pe_load_weight_q <= pe_load_weight_d;
      pe_weight_q      <= pe_weight_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    skew_delay_line #(
      .DEPTH      (i + 1),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew (
      .clk   (clk),
      .reset (reset),
      .en    (step_s),
      .din   (row_din_s[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
      .dout  (pe_input[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pe_valid       = pe_valid_q;
  assign pe_load_weight = pe_load_weight_q;
  assign pe_weight      = pe_weight_q;

endmodule

// File: tb/tb_systolic_array_feeder.sv
// Directed bench for systolic_array_feeder with a behavioural 4x4 PE-array
// model that turns the feeder outputs into bottom-row results.
module tb_systolic_array_feeder;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = 8;
  localparam int BW = N * DW;

  logic          clk = 1'b0;
  logic          reset, start, reuse_weights;
  logic [CW-1:0] num_vectors;
  logic          busy, done, w_valid, w_ready, a_valid, a_ready, pe_valid;
  logic [BW-1:0] w_data, a_data, pe_weight, pe_input;
  logic [N-1:0]  pe_load_weight;

  int n_checks = 0;
  int n_fail   = 0;

  systolic_array_feeder #(.DATA_WIDTH(DW), .N(N), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .reuse_weights(reuse_weights),
    .num_vectors(num_vectors), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .pe_load_weight(pe_load_weight), .pe_weight(pe_weight),
    .pe_valid(pe_valid), .pe_input(pe_input)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  // Activation vector k: slice i = 4k+i+1.  Weight row r: slice j = (r+1)(j+1).
  function automatic logic [31:0] vec(input int k);
    return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
  endfunction
  function automatic logic [31:0] wrow(input int r);
    return {8'(4*(r+1)), 8'(3*(r+1)), 8'(2*(r+1)), 8'(r+1)};
  endfunction
  function automatic int gold(input int k, input int j);
    int s = 0;
    for (int i = 0; i < N; i++) s += (4*k+i+1) * ((i+1)*(j+1));
    return s;
  endfunction

  // Weight-stationary PE array model: act moves right, psum moves down.
  int w_m[N][N];
  int act_m[N][N];
  int ps_m[N][N];
  int res_m[4][N];
  int step_m;

  task automatic model_clear();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin act_m[i][j] = 0; ps_m[i][j] = 0; end
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < N; j++) res_m[k][j] = -1;
    step_m = 0;
  endtask

  task automatic model_sample();
    int na[N][N];
    int np[N][N];
    int ain, k;
    for (int i = 0; i < N; i++)
      if (pe_load_weight[i])
        for (int j = 0; j < N; j++) w_m[i][j] = int'(pe_weight[j*DW +: DW]);
    if (pe_valid) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ain = (j == 0) ? int'(pe_input[i*DW +: DW]) : act_m[i][j-1];
          na[i][j] = ain;
          np[i][j] = ((i == 0) ? 0 : ps_m[i-1][j]) + w_m[i][j] * ain;
        end
      act_m = na;
      ps_m  = np;
      for (int j = 0; j < N; j++) begin
        k = step_m - (N - 1) - j;
        if (k >= 0 && k < 4) res_m[k][j] = ps_m[N-1][j];
      end
      step_m++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_sample();
  endtask

  task automatic check_res(input string tag, input int nvec);
    for (int k = 0; k < nvec; k++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s psum[%0d][%0d]", tag, k, j), res_m[k][j], gold(k, j));
  endtask

  task automatic kick(input logic reuse, input int k);
    start = 1'b1; reuse_weights = reuse; num_vectors = CW'(k);
    tick();
    start = 1'b0;
  endtask

  // Streams nvec vectors back-to-back until done; reports what it saw.
  task automatic run_vecs(input string tag, input int nvec, input int exp_valid);
    int idx = 0, last_v = -1, vcnt = 0, lcnt = 0, dcnt = 0, gap = -1;
    bit acc;
    for (int c = 0; c < 40; c++) begin
      a_valid = (idx < nvec);
      a_data  = vec(idx);
      acc     = a_valid && a_ready;
      tick();
      if (acc) idx++;
      if (pe_valid) begin vcnt++; last_v = c; end
      if (|pe_load_weight) lcnt++;
      if (done) begin dcnt++; gap = c - last_v; break; end
    end
    a_valid = 1'b0;
    check({tag, " done seen"}, dcnt, 1);
    check({tag, " pe_valid cycles"}, vcnt, exp_valid);
    check({tag, " load strobes"}, lcnt, 0);
    check({tag, " done after last valid"}, gap, 1);
    tick();
    check({tag, " done one cycle"}, {31'd0, done}, 32'd0);
  endtask

  typedef struct {
    logic        av;
    logic [31:0] ad;
    logic        ev;
    logic [31:0] ei;
    logic        ed;
    logic        eb;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic av, input logic [31:0] ad, input logic ev,
                              input logic [31:0] ei, input logic ed, input logic eb);
    tbl.push_back('{av, ad, ev, ei, ed, eb});
  endfunction

  task automatic apply_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      a_valid = tbl[i].av;
      a_data  = tbl[i].ad;
      tick();
      check($sformatf("%s[%0d] pe_valid", tag, i), {31'd0, pe_valid}, {31'd0, tbl[i].ev});
      check($sformatf("%s[%0d] pe_input", tag, i), pe_input, tbl[i].ei);
      check($sformatf("%s[%0d] done", tag, i), {31'd0, done}, {31'd0, tbl[i].ed});
      check($sformatf("%s[%0d] busy", tag, i), {31'd0, busy}, {31'd0, tbl[i].eb});
    end
    a_valid = 1'b0;
  endtask

  // Common tail of the K=3 run once vector 2 has been accepted.
  function automatic void add_k3_tail();
    add(1'b0, 32'h0, 1'b1, 32'h04070a00, 1'b0, 1'b1);
    add(1'b0, 32'h0, 1'b1, 32'h080b0000, 1'b0, 1'b1);
    add(1'b0, 32'h0, 1'b1, 32'h0c000000, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
    add(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    add(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; reuse_weights = 1'b0; num_vectors = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) w_m[i][j] = 0;
    model_clear();
    tick(); tick();
    check("reset busy/done/valid", {29'd0, busy, done, pe_valid}, 32'd0);
    check("reset load/ready", {26'd0, pe_load_weight, w_ready, a_ready}, 32'd0);
    check("reset pe_weight", pe_weight, 32'd0);
    check("reset pe_input", pe_input, 32'd0);
    reset = 1'b0;
    tick();
    check("idle busy", {31'd0, busy}, 32'd0);

    // Weight load with w_valid held, then a single vector.
    kick(1'b0, 1);
    check("load entry w_ready", {31'd0, w_ready}, 32'd1);
    check("load entry busy", {31'd0, busy}, 32'd1);
    check("load entry strobe", {28'd0, pe_load_weight}, 32'd0);
    for (int r = 0; r < N; r++) begin
      w_valid = 1'b1;
      w_data  = wrow(r);
      tick();
      check($sformatf("load row %0d strobe", r), {28'd0, pe_load_weight}, 32'd1 << r);
      check($sformatf("load row %0d weight", r), pe_weight, wrow(r));
      check($sformatf("load row %0d w_ready", r), {31'd0, w_ready}, (r < N-1) ? 32'd1 : 32'd0);
    end
    w_valid = 1'b0;
    model_clear();
    run_vecs("k1", 1, 7);
    check_res("k1", 1);

    // K=3 with reused weights, continuous a_valid.
    model_clear();
    kick(1'b1, 3);
    check("k3 entry a_ready", {31'd0, a_ready}, 32'd1);
    check("k3 entry pe_valid", {31'd0, pe_valid}, 32'd0);
    tbl.delete();
    add(1'b1, vec(0), 1'b1, 32'h00000001, 1'b0, 1'b1);
    add(1'b1, vec(1), 1'b1, 32'h00000205, 1'b0, 1'b1);
    add(1'b1, vec(2), 1'b1, 32'h00030609, 1'b0, 1'b1);
    add_k3_tail();
    apply_table("k3");
    check_res("k3", 3);

    // Same run with a two-cycle stall after vector 0.
    model_clear();
    kick(1'b1, 3);
    tbl.delete();
    add(1'b1, vec(0), 1'b1, 32'h00000001, 1'b0, 1'b1);
    add(1'b0, vec(1), 1'b0, 32'h00000001, 1'b0, 1'b1);
    add(1'b0, vec(1), 1'b0, 32'h00000001, 1'b0, 1'b1);
    add(1'b1, vec(1), 1'b1, 32'h00000205, 1'b0, 1'b1);
    add(1'b1, vec(2), 1'b1, 32'h00030609, 1'b0, 1'b1);
    add_k3_tail();
    apply_table("k3stall");
    check_res("k3stall", 3);

    // Reuse with K=2: straight to STREAM, no weight strobes.
    model_clear();
    kick(1'b1, 2);
    check("k2 stream entry", {31'd0, a_ready}, 32'd1);
    check("k2 no strobe", {28'd0, pe_load_weight}, 32'd0);
    run_vecs("k2", 2, 8);
    check_res("k2", 2);

    // Reuse with K=0 and a second start while busy.
    kick(1'b1, 0);
    check("k0 busy", {30'd0, busy, done}, 32'h2);
    check("k0 no valid", {31'd0, pe_valid}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("k0 done", {30'd0, busy, done}, 32'h1);
    check("k0 no valid 2", {31'd0, pe_valid}, 32'd0);
    tick();
    check("k0 restart ignored", {29'd0, busy, done, pe_valid}, 32'd0);

    // Reset in the middle of STREAM after two vectors.
    model_clear();
    kick(1'b1, 3);
    a_valid = 1'b1; a_data = vec(0);
    tick();
    a_data = vec(1);
    tick();
    a_valid = 1'b0;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("midreset busy/done/valid", {29'd0, busy, done, pe_valid}, 32'd0);
    check("midreset load/ready", {26'd0, pe_load_weight, w_ready, a_ready}, 32'd0);
    check("midreset pe_weight", pe_weight, 32'd0);
    check("midreset pe_input", pe_input, 32'd0);
    #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("post-reset %0d busy/done", c), {30'd0, busy, done}, 32'd0);
    end
    model_clear();
    kick(1'b1, 1);
    run_vecs("post-reset k1", 1, 7);
    check_res("post-reset", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
